// File: rtl/mux4to1_x32_if.sv
// mux4to1_x32_if -- bus bundle for the 4:1 datapath multiplexer.
//   a0..a3  : data inputs (WIDTH bits), selected by s = 00/01/10/11
//   s       : 2-bit select code
//   en      : load enable for the registered copies
//   y       : combinational selected word
//   y_q     : registered selected word
//   s_q     : registered select code
//   sel_chg : one-cycle flag, select code differed from s_q at the last load
//   y_par   : even-parity bit of y_q (only when MUX_PARITY_EN is defined)
// Modports: master drives data/select/enable; slave is the multiplexer.
interface mux4to1_x32_if #(
  parameter int unsigned WIDTH = 32
);
  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] a2;
  logic [WIDTH-1:0] a3;
  logic [1:0]       s;
  logic             en;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] y_q;
  logic [1:0]       s_q;
  logic             sel_chg;
`ifdef MUX_PARITY_EN
  logic             y_par;
`endif

  modport master (
    output a0, a1, a2, a3, s, en,
`ifdef MUX_PARITY_EN
    input  y_par,
`endif
    input  y, y_q, s_q, sel_chg
  );

  modport slave (
    input  a0, a1, a2, a3, s, en,
`ifdef MUX_PARITY_EN
    output y_par,
`endif
    output y, y_q, s_q, sel_chg
  );
endinterface

// File: rtl/mux4to1_x32.sv
// mux4to1_x32 -- four-input, WIDTH-bit multiplexer for CPU datapath select
// points (write-back source, ALU operand, next-PC).
// Ports:
//   clk : rising-edge clock
//   rst : synchronous, active-high reset (overrides en)
//   bus : mux4to1_x32_if.slave
//         y       = combinational selection, independent of clk/rst/en
//         y_q/s_q = word and select captured on an enabled edge
//         sel_chg = 1 for one cycle after a load whose s differed from s_q
// Optional feature: define MUX_PARITY_EN to add bus.y_par, the registered
// XOR-reduction of y_q (1 for an odd number of ones), aligned with y_q.
module mux4to1_x32 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic            clk,
  input  logic            rst,
  mux4to1_x32_if.slave    bus
);

  logic [WIDTH-1:0] y_sel;
  logic [WIDTH-1:0] y_d;
  logic [WIDTH-1:0] y_q;
  logic [1:0]       s_d;
  logic [1:0]       s_q;
  logic             sel_chg_d;
  logic             sel_chg_q;

  // Unknown select propagates as all-X in simulation; synthesis sees a full
  // case and treats the default as don't-care, so no latch is implied.
  always_comb begin
    y_sel = 'x;
    case (bus.s)
      2'b00:   y_sel = bus.a0;
      2'b01:   y_sel = bus.a1;
      2'b10:   y_sel = bus.a2;
      2'b11:   y_sel = bus.a3;
      default: y_sel = 'x;
    endcase
  end

  // sel_chg is a pulse: it is cleared on every edge without a load.
  always_comb begin
    y_d       = y_q;
    s_d       = s_q;
    sel_chg_d = 1'b0;
    if (bus.en) begin
      y_d       = y_sel;
      s_d       = bus.s;
      sel_chg_d = (bus.s != s_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q       <= '0;
      s_q       <= '0;
      sel_chg_q <= 1'b0;
    end else begin
      y_q       <= y_d;
      s_q       <= s_d;
      sel_chg_q <= sel_chg_d;
    end
  end

`ifdef MUX_PARITY_EN
  logic y_par_d;
  logic y_par_q;

  // Computed from the word being loaded so it lands on the same edge as y_q.
  always_comb begin
    y_par_d = y_par_q;
    if (bus.en) begin
      y_par_d = ^y_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_par_q <= 1'b0;
    end else begin
      y_par_q <= y_par_d;
    end
  end

  assign bus.y_par = y_par_q;
`endif

  assign bus.y       = y_sel;
  assign bus.y_q     = y_q;
  assign bus.s_q     = s_q;
  assign bus.sel_chg = sel_chg_q;

endmodule

// File: tb/tb_mux4to1_x32.sv
// tb_mux4to1_x32 -- directed self-checking bench for mux4to1_x32.
// Build with +define+MUX_PARITY_EN to also exercise y_par.
module tb_mux4to1_x32;

  localparam int unsigned WIDTH = 32;

  logic clk;
  logic rst;

  int unsigned n_checks;
  int unsigned n_fail;

  mux4to1_x32_if #(.WIDTH(WIDTH)) bus ();

  mux4to1_x32 #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One active edge, then sample on the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [1:0]  sweep_s   [4];
  logic [31:0] sweep_exp [4];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    bus.en   = 1'b0;
    bus.s    = 2'b00;
    bus.a0   = 32'h0000_0000;
    bus.a1   = 32'h0000_0001;
    bus.a2   = 32'h0000_0010;
    bus.a3   = 32'h0000_0011;
    sweep_s   = '{2'b00, 2'b01, 2'b10, 2'b11};
    sweep_exp = '{32'h0, 32'h1, 32'h10, 32'h11};

    // Combinational sweep, three passes, 10 ns per code.
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 4; i++) begin
        bus.s = sweep_s[i];
        #1;
        check($sformatf("sweep_y_p%0d_s%0d", p, i), bus.y, sweep_exp[i]);
        #9;
      end
    end

    // Reset with en=1, s=11.
    @(negedge clk);
    rst    = 1'b1;
    bus.en = 1'b1;
    bus.s  = 2'b11;
    step();
    check("rst_y_q",     bus.y_q,     32'h0);
    check("rst_s_q",     {30'd0, bus.s_q}, 32'h0);
    check("rst_sel_chg", {31'd0, bus.sel_chg}, 32'h0);
    check("rst_y",       bus.y,       32'h11);
`ifdef MUX_PARITY_EN
    check("rst_y_par",   {31'd0, bus.y_par}, 32'h0);
`endif

    // Registered load s=10, then the same code again.
    rst   = 1'b0;
    bus.s = 2'b10;
    step();
    check("load_y_q",     bus.y_q,     32'h10);
    check("load_s_q",     {30'd0, bus.s_q}, 32'h2);
    check("load_sel_chg", {31'd0, bus.sel_chg}, 32'h1);
    bus.a2 = 32'h0000_0020;
    step();
    check("reload_sel_chg", {31'd0, bus.sel_chg}, 32'h0);
    check("reload_y_q",     bus.y_q,     32'h20);
    bus.a2 = 32'h0000_0010;
    step();

    // Hold: en=0, new select and data.
    bus.en = 1'b0;
    bus.s  = 2'b01;
    bus.a1 = 32'hDEAD_BEEF;
    #1;
    check("hold_y_comb", bus.y, 32'hDEAD_BEEF);
    @(negedge clk);
    step();
    check("hold_y_q",     bus.y_q,     32'h10);
    check("hold_s_q",     {30'd0, bus.s_q}, 32'h2);
    check("hold_sel_chg", {31'd0, bus.sel_chg}, 32'h0);

    // Load a3=FFFFFFFF with s=11, then reset mid-stream.
    bus.a3 = 32'hFFFF_FFFF;
    bus.s  = 2'b11;
    bus.en = 1'b1;
    step();
    check("ff_y_q",     bus.y_q,     32'hFFFF_FFFF);
    check("ff_sel_chg", {31'd0, bus.sel_chg}, 32'h1);
`ifdef MUX_PARITY_EN
    check("ff_y_par",   {31'd0, bus.y_par}, 32'h0);
`endif
    rst = 1'b1;
    step();
    check("mid_rst_y_q",     bus.y_q,     32'h0);
    check("mid_rst_s_q",     {30'd0, bus.s_q}, 32'h0);
    check("mid_rst_sel_chg", {31'd0, bus.sel_chg}, 32'h0);
    check("mid_rst_y",       bus.y,       32'hFFFF_FFFF);
    rst = 1'b0;
    step();
    check("post_rst_sel_chg", {31'd0, bus.sel_chg}, 32'h1);
    check("post_rst_y_q",     bus.y_q,     32'hFFFF_FFFF);
    check("post_rst_s_q",     {30'd0, bus.s_q}, 32'h3);

    // Pulse falls when en drops.
    bus.en = 1'b0;
    step();
    check("pulse_end_sel_chg", {31'd0, bus.sel_chg}, 32'h0);
    check("pulse_end_y_q",     bus.y_q,     32'hFFFF_FFFF);

    // First load after reset with s=00 sees no change.
    rst    = 1'b1;
    bus.en = 1'b1;
    bus.s  = 2'b00;
    step();
    rst    = 1'b0;
    bus.a0 = 32'h1234_5678;
    step();
    check("first00_sel_chg", {31'd0, bus.sel_chg}, 32'h0);
    check("first00_y_q",     bus.y_q,     32'h1234_5678);

`ifdef MUX_PARITY_EN
    bus.a3 = 32'h0000_0011;
    bus.s  = 2'b11;
    step();
    check("par_11", {31'd0, bus.y_par}, 32'h0);
    bus.a2 = 32'h0000_0010;
    bus.s  = 2'b10;
    step();
    check("par_10", {31'd0, bus.y_par}, 32'h1);
    bus.en = 1'b0;
    bus.a2 = 32'h0000_0000;
    step();
    check("par_hold", {31'd0, bus.y_par}, 32'h1);
    bus.en = 1'b1;
    bus.a3 = 32'hFFFF_FFFF;
    bus.s  = 2'b11;
    step();
    check("par_ff", {31'd0, bus.y_par}, 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
